// File: rtl/display_page_arbiter_if.sv
// Bundle between the counter/FSM requesters, the page arbiter and the seven-segment driver.
interface display_page_arbiter_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 32,
    parameter int unsigned HOLD_W = 8
);
    logic                en;
    logic [HOLD_W-1:0]   hold;
    logic [N-1:0]        req;
    logic [N*W-1:0]      num_flat;
    logic [N*8-1:0]      dots_flat;
    logic [N-1:0]        grant;
    logic [2:0]          page;
    logic                valid;
    logic [W-1:0]        num;
    logic [7:0]          dots;

    modport master (
        output en, hold, req, num_flat, dots_flat,
        input  grant, page, valid, num, dots
    );

    modport slave (
        input  en, hold, req, num_flat, dots_flat,
        output grant, page, valid, num, dots
    );
endinterface

// File: rtl/display_page_arbiter.sv
// Round-robin owner of the seven-segment display: each requester keeps its page for
// a programmable number of strobe ticks, or until it drops its request.
module display_page_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 32,
    parameter int unsigned HOLD_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    display_page_arbiter_if.slave   bus
);
    localparam int unsigned PW = 3;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [PW-1:0]      last;

    logic [7:0]         req_x_c;
    logic [PW-1:0]      arb_from_c;
    logic [PW-1:0]      idx_c;
    logic [PW-1:0]      win_c;
    logic               win_found_c;
    logic [HOLD_W-1:0]  load_cnt_c;
    logic               expire_c;
    logic               release_c;
    logic               done_c;
    logic [W-1:0]       sel_num_c;
    logic [7:0]         sel_dots_c;

    // In SHOW the outgoing page becomes "last" on the same edge, so search from it directly.
    always_comb begin
        req_x_c     = 8'(bus.req);
        arb_from_c  = (state == SHOW) ? bus.page : last;
        idx_c       = '0;
        win_c       = '0;
        win_found_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            idx_c = PW'((32'(arb_from_c) + 32'(i) + 32'd1) % N);
            if (!win_found_c && req_x_c[idx_c]) begin
                win_c       = idx_c;
                win_found_c = 1'b1;
            end
        end
    end

    always_comb begin
        sel_num_c  = '0;
        sel_dots_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.page == PW'(i)) begin
                sel_num_c  = bus.num_flat[i*W +: W];
                sel_dots_c = bus.dots_flat[i*8 +: 8];
            end
        end
    end

    // A zero hold behaves as one tick; expiry and release share one hand-over path.
    always_comb begin
        load_cnt_c = (bus.hold == '0) ? HOLD_W'(1) : bus.hold;
        expire_c   = bus.en && (hold_cnt == HOLD_W'(1));
        release_c  = !req_x_c[bus.page];
        done_c     = (state == SHOW) && (expire_c || release_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus.grant <= '0;
            bus.page  <= '0;
            bus.valid <= 1'b0;
            hold_cnt  <= '0;
            last      <= PW'(N - 1);
            bus.num   <= '0;
            bus.dots  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.num  <= '0;
                    bus.dots <= '0;
                    if (win_found_c) begin
                        state     <= SHOW;
                        bus.grant <= N'(1) << win_c;
                        bus.page  <= win_c;
                        bus.valid <= 1'b1;
                        hold_cnt  <= load_cnt_c;
                    end
                end
                SHOW: begin
                    if (done_c) begin
                        last <= bus.page;
                        if (win_found_c) begin
                            bus.grant <= N'(1) << win_c;
                            bus.page  <= win_c;
                            hold_cnt  <= load_cnt_c;
                            bus.num   <= sel_num_c;
                            bus.dots  <= sel_dots_c;
                        end else begin
                            state     <= IDLE;
                            bus.grant <= '0;
                            bus.valid <= 1'b0;
                            hold_cnt  <= '0;
                            bus.num   <= '0;
                            bus.dots  <= '0;
                        end
                    end else begin
                        bus.num  <= sel_num_c;
                        bus.dots <= sel_dots_c;
                        if (bus.en) begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
